// File: rtl/break_watch_unit_if.sv
// Bus bundle between the CPU/debug front end and the break/watch unit.
interface break_watch_unit_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              iCpuTick;
  logic [ADDR_W-1:0] iPC;
  logic [ADDR_W-1:0] iDAddress;
  logic              iDReadEnable;
  logic              iDWriteEnable;
  logic              iExtBreak;
  logic              iResume;
  logic              iStep;
  logic              iCfgWrite;
  logic [SelW-1:0]   iCfgSel;
  logic [1:0]        iCfgMode;
  logic [ADDR_W-1:0] iCfgAddr;
  logic [ADDR_W-1:0] iCfgMask;
  logic [CNT_W-1:0]  iCfgCount;
  logic              oBreak;
  logic [SelW-1:0]   oBreakId;
  logic [1:0]        oCause;
  logic [NUM_CH-1:0] oHitMask;
  logic [1:0]        oState;

  modport master (
    output iCpuTick, iPC, iDAddress, iDReadEnable, iDWriteEnable, iExtBreak, iResume, iStep,
    output iCfgWrite, iCfgSel, iCfgMode, iCfgAddr, iCfgMask, iCfgCount,
    input  oBreak, oBreakId, oCause, oHitMask, oState
  );

  modport slave (
    input  iCpuTick, iPC, iDAddress, iDReadEnable, iDWriteEnable, iExtBreak, iResume, iStep,
    input  iCfgWrite, iCfgSel, iCfgMode, iCfgAddr, iCfgMask, iCfgCount,
    output oBreak, oBreakId, oCause, oHitMask, oState
  );
endinterface

// File: rtl/break_watch_unit.sv
// Multi-channel breakpoint/watchpoint unit. Runs on the free-running clock, samples CPU buses
// only on iCpuTick, and requests a CPU clock freeze through oBreak while halted.
module break_watch_unit #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 8
) (
  input logic              iCLK,
  input logic              iRST,
  break_watch_unit_if.slave bus
);
  localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ModePc = 2'b01;
  localparam logic [1:0] ModeRd = 2'b10;
  localparam logic [1:0] ModeWr = 2'b11;

  localparam logic [1:0] CauseNone = 2'b00;
  localparam logic [1:0] CauseChan = 2'b01;
  localparam logic [1:0] CauseStep = 2'b10;
  localparam logic [1:0] CauseExt  = 2'b11;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHalt = 2'd1,
    StStep = 2'd2,
    StSkip = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   id_q, id_d;
  logic [1:0]        cause_q, cause_d;
  logic [NUM_CH-1:0] hm_q, hm_d;

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] fire;
  logic [SelW-1:0]   fire_id;
  logic              eval_pc;
  logic              eval_data;

  // PC matches are masked in SKIP so the resumed instruction does not re-break.
  assign eval_pc   = bus.iCpuTick && (state_q == StRun);
  assign eval_data = bus.iCpuTick && (state_q == StRun || state_q == StSkip);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  reload_q;
    logic [ADDR_W-1:0] addr_in;
    logic              addr_eq;
    logic              cfg_sel;
    logic              mode_ok;

    assign addr_in = (mode_q == ModePc) ? bus.iPC : bus.iDAddress;
    assign addr_eq = ((addr_in ^ addr_q) & mask_q) == '0;
    assign cfg_sel = bus.iCfgWrite && (bus.iCfgSel == SelW'(g));
    assign mode_ok = ((mode_q == ModePc) && eval_pc) ||
                     ((mode_q == ModeRd) && eval_data && bus.iDReadEnable) ||
                     ((mode_q == ModeWr) && eval_data && bus.iDWriteEnable);
    // A config write to this channel discards any hit in the same cycle.
    assign hit[g]  = mode_ok && addr_eq && !cfg_sel;
    assign fire[g] = hit[g] && (cnt_q == '0);

    // Channel configuration and ignore counter.
    always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
        mode_q   <= 2'b00;
        addr_q   <= '0;
        mask_q   <= '0;
        cnt_q    <= '0;
        reload_q <= '0;
      end else if (cfg_sel) begin
        mode_q   <= bus.iCfgMode;
        addr_q   <= bus.iCfgAddr;
        mask_q   <= bus.iCfgMask;
        cnt_q    <= bus.iCfgCount;
        reload_q <= bus.iCfgCount;
      end else if (fire[g]) begin
        cnt_q <= reload_q;
      end else if (hit[g]) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Lowest-numbered firing channel wins.
  always_comb begin
    fire_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fire[i]) fire_id = SelW'(i);
    end
  end

  // Next-state and break-record logic.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cause_d = cause_q;
    hm_d    = hm_q;
    unique case (state_q)
      StRun, StSkip: begin
        if (bus.iCpuTick) begin
          if (|fire) begin
            state_d = StHalt;
            id_d    = fire_id;
            cause_d = CauseChan;
            hm_d    = hit;
          end else if (state_q == StRun && bus.iExtBreak) begin
            state_d = StHalt;
            id_d    = '0;
            cause_d = CauseExt;
            hm_d    = hit;
          end else begin
            state_d = StRun;
          end
        end
      end
      StHalt: begin
        if (bus.iStep) begin
          state_d = StStep;
        end else if (bus.iResume) begin
          state_d = StSkip;
        end
      end
      StStep: begin
        if (bus.iCpuTick) begin
          state_d = StHalt;
          id_d    = '0;
          cause_d = CauseStep;
          hm_d    = '0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // FSM state and break record registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StRun;
      id_q    <= '0;
      cause_q <= CauseNone;
      hm_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cause_q <= cause_d;
      hm_q    <= hm_d;
    end
  end

  assign bus.oBreak   = (state_q == StHalt);
  assign bus.oBreakId = id_q;
  assign bus.oCause   = cause_q;
  assign bus.oHitMask = hm_q;
  assign bus.oState   = state_q;
endmodule

// File: tb/tb_break_watch_unit.sv
// Bench for break_watch_unit: directed vector table, hand-written reset corner, random run
// against a behavioural model.
module tb_break_watch_unit;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 64;
  localparam int unsigned CW  = 8;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  break_watch_unit_if #(.NUM_CH(NCH), .ADDR_W(AW), .CNT_W(CW)) bus ();
  break_watch_unit #(.NUM_CH(NCH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  typedef struct packed {
    logic        tick;
    logic [63:0] pc;
    logic [63:0] da;
    logic        rd;
    logic        wr;
    logic        ext;
    logic        resume;
    logic        step;
    logic        cfg;
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic [63:0] caddr;
    logic [63:0] cmask;
    logic [7:0]  ccnt;
  } in_t;

  typedef struct {
    in_t        v;
    logic       brk;
    logic [1:0] st;
    logic [1:0] cause;
    logic [1:0] id;
    logic [3:0] hm;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: state 0 run, 1 halt, 2 step, 3 skip.
  int          m_state, m_cause, m_id;
  bit [3:0]    m_hm;
  int          m_mode[4];
  logic [63:0] m_addr[4];
  logic [63:0] m_mask[4];
  int          m_cnt[4];
  int          m_reload[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_cause = 0; m_id = 0; m_hm = '0;
    for (int c = 0; c < 4; c++) begin
      m_mode[c] = 0; m_addr[c] = '0; m_mask[c] = '0; m_cnt[c] = 0; m_reload[c] = 0;
    end
  endtask

  task automatic model_cycle(input in_t v);
    bit [3:0] hits;
    int       first;
    hits  = '0;
    first = -1;
    if (m_state == 1) begin
      if (v.step) m_state = 2;
      else if (v.resume) m_state = 3;
    end else if (v.tick && m_state == 2) begin
      m_state = 1; m_cause = 2; m_id = 0; m_hm = '0;
    end else if (v.tick) begin
      for (int c = 0; c < 4; c++) begin
        logic [63:0] a;
        bit          ok;
        a  = v.da;
        ok = 1'b0;
        if (v.cfg && v.sel == c) continue;
        case (m_mode[c])
          1: begin ok = (m_state == 0); a = v.pc; end
          2: ok = v.rd;
          3: ok = v.wr;
          default: ok = 1'b0;
        endcase
        if (ok && ((a & m_mask[c]) == (m_addr[c] & m_mask[c]))) begin
          hits[c] = 1'b1;
          if (m_cnt[c] == 0) begin
            if (first < 0) first = c;
            m_cnt[c] = m_reload[c];
          end else begin
            m_cnt[c] = m_cnt[c] - 1;
          end
        end
      end
      if (first >= 0) begin
        m_state = 1; m_cause = 1; m_id = first; m_hm = hits;
      end else if (m_state == 0 && v.ext) begin
        m_state = 1; m_cause = 3; m_id = 0; m_hm = hits;
      end else begin
        m_state = 0;
      end
    end
    if (v.cfg) begin
      m_mode[v.sel] = int'(v.mode); m_addr[v.sel] = v.caddr; m_mask[v.sel] = v.cmask;
      m_cnt[v.sel] = int'(v.ccnt); m_reload[v.sel] = int'(v.ccnt);
    end
  endtask

  task automatic apply(input in_t v);
    bus.iCpuTick = v.tick;   bus.iPC = v.pc;          bus.iDAddress = v.da;
    bus.iDReadEnable = v.rd; bus.iDWriteEnable = v.wr; bus.iExtBreak = v.ext;
    bus.iResume = v.resume;  bus.iStep = v.step;       bus.iCfgWrite = v.cfg;
    bus.iCfgSel = v.sel;     bus.iCfgMode = v.mode;    bus.iCfgAddr = v.caddr;
    bus.iCfgMask = v.cmask;  bus.iCfgCount = v.ccnt;
  endtask

  task automatic check_model(input string tag);
    check({tag, " brk"},   64'(bus.oBreak),   64'(m_state == 1));
    check({tag, " state"}, 64'(bus.oState),   64'(m_state));
    check({tag, " cause"}, 64'(bus.oCause),   64'(m_cause));
    check({tag, " id"},    64'(bus.oBreakId), 64'(m_id));
    check({tag, " hm"},    64'(bus.oHitMask), 64'(m_hm));
  endtask

  // One iCLK cycle: drive at negedge, step the model, compare at the next negedge.
  task automatic cycle(input in_t v, input string tag);
    apply(v);
    model_cycle(v);
    @(posedge iCLK);
    @(negedge iCLK);
    check_model(tag);
  endtask

  function automatic in_t t_pc(input logic [63:0] pc, input logic ext = 1'b0);
    in_t v = '0;
    v.tick = 1'b1; v.pc = pc; v.ext = ext;
    return v;
  endfunction

  function automatic in_t t_wr(input logic [63:0] pc, input logic [63:0] da);
    in_t v = '0;
    v.tick = 1'b1; v.pc = pc; v.da = da; v.wr = 1'b1;
    return v;
  endfunction

  function automatic in_t c_cfg(input logic [1:0] sel, input logic [1:0] mode,
                                input logic [63:0] addr, input logic [63:0] mask,
                                input logic [7:0] cnt);
    in_t v = '0;
    v.cfg = 1'b1; v.sel = sel; v.mode = mode; v.caddr = addr; v.cmask = mask; v.ccnt = cnt;
    return v;
  endfunction

  function automatic in_t p_ctl(input logic step, input logic resume);
    in_t v = '0;
    v.step = step; v.resume = resume;
    return v;
  endfunction

  function automatic vec_t row(input in_t v, input logic brk, input logic [1:0] st,
                               input logic [1:0] cause, input logic [1:0] id,
                               input logic [3:0] hm);
    vec_t r;
    r.v = v; r.brk = brk; r.st = st; r.cause = cause; r.id = id; r.hm = hm;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    in_t idle;
    idle = '0;
    // PC breakpoint on ch0
    tbl.push_back(row(c_cfg(2'd0, 2'b01, 64'h0040_0010, Ones, 8'd0), 0, 0, 0, 0, 4'h0));
    tbl.push_back(row(t_pc(64'h0040_0000), 0, 0, 0, 0, 4'h0));
    tbl.push_back(row(t_pc(64'h0040_0004), 0, 0, 0, 0, 4'h0));
    tbl.push_back(row(t_pc(64'h0040_0008), 0, 0, 0, 0, 4'h0));
    tbl.push_back(row(t_pc(64'h0040_000C), 0, 0, 0, 0, 4'h0));
    tbl.push_back(row(t_pc(64'h0040_0010), 1, 1, 1, 0, 4'h1));
    tbl.push_back(row(p_ctl(1'b0, 1'b1), 0, 3, 1, 0, 4'h1));
    tbl.push_back(row(t_pc(64'h0040_0014), 0, 0, 1, 0, 4'h1));
    // Data-write watchpoint with ignore count 2
    tbl.push_back(row(c_cfg(2'd2, 2'b11, 64'h1001_0000, ~64'hFF, 8'd2), 0, 0, 1, 0, 4'h1));
    tbl.push_back(row(t_wr(64'h0040_0020, 64'h1001_0004), 0, 0, 1, 0, 4'h1));
    tbl.push_back(row(t_wr(64'h0040_0024, 64'h1001_0004), 0, 0, 1, 0, 4'h1));
    tbl.push_back(row(t_wr(64'h0040_0028, 64'h1001_0004), 1, 1, 1, 2, 4'h4));
    tbl.push_back(row(p_ctl(1'b0, 1'b1), 0, 3, 1, 2, 4'h4));
    tbl.push_back(row(t_pc(64'h0040_0030), 0, 0, 1, 2, 4'h4));
    // Two channels on the same PC
    tbl.push_back(row(c_cfg(2'd0, 2'b00, 64'h0, 64'h0, 8'd0), 0, 0, 1, 2, 4'h4));
    tbl.push_back(row(c_cfg(2'd1, 2'b01, 64'h0050_0000, Ones, 8'd0), 0, 0, 1, 2, 4'h4));
    tbl.push_back(row(c_cfg(2'd3, 2'b01, 64'h0050_0000, Ones, 8'd0), 0, 0, 1, 2, 4'h4));
    tbl.push_back(row(t_pc(64'h0050_0000), 1, 1, 1, 1, 4'hA));
    // Resume skips the same PC once
    tbl.push_back(row(p_ctl(1'b0, 1'b1), 0, 3, 1, 1, 4'hA));
    tbl.push_back(row(t_pc(64'h0050_0000), 0, 0, 1, 1, 4'hA));
    tbl.push_back(row(t_pc(64'h0050_0000), 1, 1, 1, 1, 4'hA));
    // Step beats resume; exactly one tick
    tbl.push_back(row(p_ctl(1'b1, 1'b1), 0, 2, 1, 1, 4'hA));
    tbl.push_back(row(idle, 0, 2, 1, 1, 4'hA));
    tbl.push_back(row(t_pc(64'h0050_0004), 1, 1, 2, 0, 4'h0));
    tbl.push_back(row(p_ctl(1'b0, 1'b1), 0, 3, 2, 0, 4'h0));
    tbl.push_back(row(t_pc(64'h0060_0000), 0, 0, 2, 0, 4'h0));
    // External break vs channel fire
    tbl.push_back(row(c_cfg(2'd0, 2'b01, 64'h0060_0008, Ones, 8'd0), 0, 0, 2, 0, 4'h0));
    tbl.push_back(row(t_pc(64'h0060_0008, 1'b1), 1, 1, 1, 0, 4'h1));
    tbl.push_back(row(p_ctl(1'b0, 1'b1), 0, 3, 1, 0, 4'h1));
    tbl.push_back(row(t_pc(64'h0060_0010), 0, 0, 1, 0, 4'h1));
    tbl.push_back(row(t_pc(64'h0060_0014, 1'b1), 1, 1, 3, 0, 4'h0));

    // Reset
    apply(idle);
    iRST = 1'b1;
    model_reset();
    repeat (2) @(negedge iCLK);
    check_model("reset");
    iRST = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      cycle(tbl[i].v, tag);
      check({tag, " exp_brk"},   64'(bus.oBreak),   64'(tbl[i].brk));
      check({tag, " exp_state"}, 64'(bus.oState),   64'(tbl[i].st));
      check({tag, " exp_cause"}, 64'(bus.oCause),   64'(tbl[i].cause));
      check({tag, " exp_id"},    64'(bus.oBreakId), 64'(tbl[i].id));
      check({tag, " exp_hm"},    64'(bus.oHitMask), 64'(tbl[i].hm));
    end

    // Reset while halted: oBreak must drop without waiting for a clock edge
    #2;
    iRST = 1'b1;
    #2;
    check("rst_async brk",   64'(bus.oBreak),   64'd0);
    check("rst_async state", 64'(bus.oState),   64'd0);
    check("rst_async cause", 64'(bus.oCause),   64'd0);
    check("rst_async id",    64'(bus.oBreakId), 64'd0);
    check("rst_async hm",    64'(bus.oHitMask), 64'd0);
    model_reset();
    @(negedge iCLK);
    iRST = 1'b0;
    cycle(t_pc(64'h0060_0008), "post_rst");
    check("post_rst no_break", 64'(bus.oBreak), 64'd0);

    // Random run against the model
    for (int n = 0; n < 3000; n++) begin
      in_t v;
      int  k;
      v        = '0;
      v.tick   = 1'($urandom_range(0, 1));
      v.pc     = 64'h1000 + 64'(4 * $urandom_range(0, 7));
      v.da     = 64'h2000 + 64'(4 * $urandom_range(0, 7));
      v.rd     = 1'($urandom_range(0, 1));
      v.wr     = 1'($urandom_range(0, 1));
      v.ext    = ($urandom_range(0, 19) == 0);
      v.resume = ($urandom_range(0, 3) == 0);
      v.step   = ($urandom_range(0, 7) == 0);
      v.cfg    = ($urandom_range(0, 11) == 0);
      v.sel    = 2'($urandom_range(0, 3));
      v.mode   = 2'($urandom_range(0, 3));
      v.caddr  = ((v.mode == 2'b01) ? 64'h1000 : 64'h2000) + 64'(4 * $urandom_range(0, 7));
      k        = $urandom_range(0, 3);
      v.cmask  = (k == 0) ? Ones : (k == 1) ? ~64'hF : (k == 2) ? 64'h0 : ~64'h8;
      v.ccnt   = 8'($urandom_range(0, 2));
      if (n == 1500) begin
        apply('0);
        iRST = 1'b1;
        model_reset();
        @(negedge iCLK);
        iRST = 1'b0;
        check_model("rnd_rst");
      end
      cycle(v, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/break_watch_unit.md
Name: break_watch_unit

Overview:
- Parametrised successor to the single-breakpoint break logic: NUM_CH independent breakpoint/watchpoint channels, each matching PC execution, data read or data write at a masked address.
- Per-channel ignore counts, single-step and external break request.
- Runs on the free-running system clock and drives oBreak, which the clock interface uses to freeze the CPU clock.
- CPU-side buses are sampled only on iCpuTick, a one-cycle strobe marking each CPU clock edge.

Parameters:
NUM_CH, 4, number of channels (1..16)
ADDR_W, 64, address width of PC and data bus
CNT_W, 8, ignore-count width

Ports:
iCLK  in  1  free-running clock (50 MHz domain)
iRST  in  1  asynchronous active-high reset
iCpuTick  in  1  one-cycle strobe per CPU clock edge; qualifies all bus sampling
iPC  in  ADDR_W  current PC
iDAddress  in  ADDR_W  data bus address
iDReadEnable  in  1  data read strobe
iDWriteEnable  in  1  data write strobe
iExtBreak  in  1  external break request (key), level
iResume  in  1  resume pulse
iStep  in  1  single-step pulse
iCfgWrite  in  1  configuration write strobe
iCfgSel  in  $clog2(NUM_CH)  channel selected for configuration
iCfgMode  in  2  channel mode: 00 off, 01 PC exec, 10 data read, 11 data write
iCfgAddr  in  ADDR_W  match address
iCfgMask  in  ADDR_W  compare mask; 1 = bit compared
iCfgCount  in  CNT_W  ignore count: fire on hit number iCfgCount+1
oBreak  out  1  CPU clock freeze request
oBreakId  out  $clog2(NUM_CH)  channel that fired
oCause  out  2  break cause: 00 none, 01 channel, 10 step, 11 external
oHitMask  out  NUM_CH  channels matching on the breaking tick
oState  out  2  FSM state, for display

Behaviour:
- Reset (async):
  - All channels mode off; addr, mask and counters cleared.
  - FSM in RUN.
  - oBreak=0, oBreakId=0, oCause=00, oHitMask=0, oState=RUN.
- Channel match:
  - Condition: (addr_in & mask) == (cfg_addr & mask), where addr_in is iPC for mode 01 and iDAddress for modes 10/11.
  - Mode 10 also requires iDReadEnable; mode 11 requires iDWriteEnable.
  - Evaluated only in a cycle with iCpuTick=1. Mask 0 matches every address.
- Ignore count: a hit with counter==0 fires; a hit with counter>0 decrements the counter and does not fire. Counter reloads from cfg count when the channel fires.
- Config write:
  - Loads mode, addr, mask and counter of channel iCfgSel on the next iCLK edge.
  - A hit on the same channel in the same cycle is discarded (config wins).
  - Allowed in any state.
- FSM states: RUN=0, HALT=1, STEP=2, SKIP=3.
- RUN:
  - On iCpuTick with >=1 firing channel: go to HALT; oBreakId = lowest firing index; oCause=01; oHitMask = all matching channels.
  - Otherwise, if iExtBreak=1: go to HALT with oCause=11. A channel fire takes priority over iExtBreak in the same cycle.
- HALT:
  - oBreak=1, asserted combinationally from state (registered state, so oBreak rises one iCLK after the breaking tick).
  - iStep: go to STEP, oBreak=0. iStep wins over iResume if both are asserted.
  - iResume: go to SKIP, oBreak=0.
  - iExtBreak is ignored in HALT.
- STEP: on the next iCpuTick go to HALT with oCause=10; channel matches on that tick are not evaluated. Exactly one CPU instruction executes.
- SKIP:
  - On the next iCpuTick, PC-mode (01) matches are suppressed so the resumed instruction does not re-break. Data-mode channels are still evaluated and may fire (go to HALT).
  - Otherwise go to RUN.
- iCpuTick absent: no state change except config and iResume/iStep in HALT.
- oBreakId, oCause and oHitMask hold until the next break. Resume does not clear them.
- Reset mid-HALT: oBreak drops asynchronously; all channels are disabled.

Test Plan:
- After reset, ch0 = PC exec, addr 0x0040_0010, mask all ones, count 0. Tick PC through 0x0040_0000..0x0040_0010 -> oBreak rises one iCLK after the 0x..10 tick; oBreakId=0, oCause=01, oHitMask=0001.
- Ch2 = data write, addr 0x1001_0000, mask 0xFFFF_FFFF_FFFF_FF00, count 2. Issue writes to 0x1001_0004 three times -> no break on the first two, break on the third; oBreakId=2.
- Ch1 and ch3 both PC exec on the same PC, break taken -> oBreakId=1, oHitMask=1010.
- In HALT, pulse iResume -> oBreak=0; the next tick at the same PC does not re-break; the tick after, PC back at the same address, breaks again.
- In HALT, pulse iStep and iResume together -> exactly one iCpuTick passes, then HALT with oCause=10.
- iExtBreak in RUN together with a ch0 fire -> oCause=01. iExtBreak alone -> oCause=11. Assert iRST in HALT -> oBreak=0 immediately and all outputs at reset values.
